// File: rtl/mem_arbiter.sv
// Two-requester burst arbiter in front of a single-port main memory (IDLE/RD/WR).
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module mem_arbiter #(
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned MEM_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c0_req,
    input  logic        c0_we,
    input  logic [31:0] c0_addr,
    input  logic [31:0] c0_wdata,
    output logic        c0_gnt,
    output logic        c0_beat,
    output logic [31:0] c0_rdata,
    output logic        c0_done,
    input  logic        c1_req,
    input  logic        c1_we,
    input  logic [31:0] c1_addr,
    input  logic [31:0] c1_wdata,
    output logic        c1_gnt,
    output logic        c1_beat,
    output logic [31:0] c1_rdata,
    output logic        c1_done,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam int unsigned BW = $clog2(BURST_LEN) + 1;
    localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [LW-1:0] LAST_LAT  = LW'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t        state_q, state_d;
    logic          id_q, id_d;
    logic          gnt_q, gnt_d;
    logic          beat_q, beat_d;
    logic          done_q, done_d;
    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    logic [31:0]   addr_q, addr_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [31:0]   rdata0_q, rdata0_d;
    logic [31:0]   rdata1_q, rdata1_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic          last_q, last_d;
`endif

    logic          win;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic          beat_end;
    logic          rd_valid;

    // Read data is passed straight through on the beat cycle and held afterwards.
    assign rd_valid = beat_q && ren_q;
    assign c0_rdata = (rd_valid && !id_q) ? mem_dout : rdata0_q;
    assign c1_rdata = (rd_valid &&  id_q) ? mem_dout : rdata1_q;

    assign c0_gnt   = gnt_q  && !id_q;
    assign c1_gnt   = gnt_q  &&  id_q;
    assign c0_beat  = beat_q && !id_q;
    assign c1_beat  = beat_q &&  id_q;
    assign c0_done  = done_q && !id_q;
    assign c1_done  = done_q &&  id_q;
    assign mem_ren  = ren_q;
    assign mem_wen  = wen_q;
    assign mem_addr = addr_q;
    assign mem_din  = wen_q ? (id_q ? c1_wdata : c0_wdata) : '0;

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        gnt_d    = gnt_q;
        beat_d   = 1'b0;
        done_d   = 1'b0;
        ren_d    = ren_q;
        wen_d    = wen_q;
        addr_d   = addr_q;
        bcnt_d   = bcnt_q;
        lcnt_d   = lcnt_q;
        rdata0_d = c0_rdata;
        rdata1_d = c1_rdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d   = last_q;
`endif
`ifdef MEM_ARB_FIXED_PRIO_EN
        win      = !c0_req;
`else
        win      = (c0_req && c1_req) ? !last_q : !c0_req;
`endif
        sel_we   = win ? c1_we   : c0_we;
        sel_addr = win ? c1_addr : c0_addr;
        beat_end = (state_q == WR) || (lcnt_q == LAST_LAT);

        case (state_q)
            IDLE: begin
                if (c0_req || c1_req) begin
                    id_d   = win;
                    gnt_d  = 1'b1;
                    addr_d = sel_addr & ~32'h3;
                    bcnt_d = '0;
                    lcnt_d = '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_d = win;
`endif
                    if (sel_we) begin
                        state_d = WR;
                        wen_d   = 1'b1;
                        beat_d  = 1'b1;
                        done_d  = (LAST_BEAT == '0);
                    end else begin
                        state_d = RD;
                        ren_d   = 1'b1;
                        beat_d  = (LAST_LAT == '0);
                        done_d  = (LAST_LAT == '0) && (LAST_BEAT == '0);
                    end
                end
            end
            RD, WR: begin
                if (beat_end) begin
                    if (bcnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        gnt_d   = 1'b0;
                        ren_d   = 1'b0;
                        wen_d   = 1'b0;
                        addr_d  = '0;
                        bcnt_d  = '0;
                        lcnt_d  = '0;
                    end else begin
                        addr_d = addr_q + 32'd4;
                        bcnt_d = bcnt_q + BW'(1);
                        lcnt_d = '0;
                        beat_d = (state_q == WR) || (LAST_LAT == '0);
                        done_d = beat_d && ((bcnt_q + BW'(1)) == LAST_BEAT);
                    end
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                    beat_d = ((lcnt_q + LW'(1)) == LAST_LAT);
                    done_d = beat_d && (bcnt_q == LAST_BEAT);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            id_q     <= 1'b0;
            gnt_q    <= 1'b0;
            beat_q   <= 1'b0;
            done_q   <= 1'b0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            bcnt_q   <= '0;
            lcnt_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            gnt_q    <= gnt_d;
            beat_q   <= beat_d;
            done_q   <= done_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            bcnt_q   <= bcnt_d;
            lcnt_q   <= lcnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 32, words per transaction (power of two, 1..256).
REQ-002 SHALL have parameter MEM_LAT, default 2, cycles mem_ren/mem_addr are held per read word (>=1).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-005 cN_req  in  1  requester N (N=0,1; 0 = data cache, 1 = instruction cache) wants a burst.
REQ-006 cN_we  in  1  1 = write burst, 0 = read burst; held stable with req.
REQ-007 cN_addr  in  32  burst base byte address; bits [1:0] ignored.
REQ-008 cN_wdata  in  32  current write word.
REQ-009 cN_gnt  out  1  requester N owns memory.
REQ-010 cN_beat  out  1  write word consumed, or cN_rdata valid, this cycle.
REQ-011 cN_rdata  out  32  read word.
REQ-012 cN_done  out  1  one-cycle pulse on final beat.
REQ-013 mem_ren, mem_wen  out  1 each  main-memory strobes.
REQ-014 mem_addr, mem_din  out  32 each  main-memory address / write data.
REQ-015 mem_dout  in  32  main-memory read data, valid MEM_LAT cycles after mem_ren first asserted with a stable address.

Function
REQ-016 States SHALL be IDLE, RD, WR; one transaction in flight at a time.
REQ-017 IDLE: if any req sampled high, SHALL select a winner and enter RD (we=0) or WR (we=1), latching base address, we and winner id; cN_gnt rises the next cycle.
REQ-018 Both requesting: winner SHALL be the requester not granted last (round-robin); last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-019 Beat k address SHALL be {base[31:2],2'b00} + 4*k, k = 0..BURST_LEN-1, modulo 2^32.
REQ-020 RD: per beat SHALL drive mem_ren=1 and mem_addr for exactly MEM_LAT cycles; in the last of them cN_rdata=mem_dout and cN_beat=1.
REQ-021 WR: per beat SHALL drive mem_wen=1, mem_addr, mem_din=cN_wdata for one cycle with cN_beat=1; requester presents word k+1 the cycle after beat k.
REQ-022 Final beat SHALL assert cN_done with cN_beat; next cycle returns to IDLE with cN_gnt=0.
REQ-023 IDLE SHALL last at least one cycle between transactions (no back-to-back grant).
REQ-024 Grant occupancy SHALL be BURST_LEN*MEM_LAT cycles for read, BURST_LEN for write.
REQ-025 Deassertion of req or change of we/addr mid-burst SHALL be ignored; burst completes on latched values.
REQ-026 Only the granted requester's gnt/beat/done SHALL ever be high; mem_ren and mem_wen never high together.
REQ-027 Beat counter SHALL be log2(BURST_LEN)+1 bits wide; latency counter sized for MEM_LAT; neither may wrap inside a burst.
REQ-028 Outside a beat cycle cN_rdata SHALL hold its last value; mem_addr/mem_din SHALL be 0 in IDLE.

Reset
REQ-029 rst=0 at a clock edge SHALL force IDLE, all outputs 0, counters 0, last-grant pointer 1, including mid-burst (burst aborted, no done).
REQ-030 First arbitration SHALL occur on the first edge with rst=1.

Configuration
REQ-031 With macro MEM_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win ties and the last-grant pointer is not implemented; undefined, REQ-018 round-robin applies.

Verification
REQ-032 BURST_LEN=4, MEM_LAT=2; c0 read at 0x0000_1003 -> mem_addr 0x1000,0x1004,0x1008,0x100C each 2 cycles, c0_beat every 2nd cycle, c0_done on 8th grant cycle.
REQ-033 c1 write base 0x20, words 0xDEADBEEF,1,2,3 -> 4 consecutive mem_wen cycles with matching addr/din, c1_done with 4th, gnt low next cycle.
REQ-034 c0 and c1 raised same cycle after reset, both held -> grant order c0,c1,c0,c1 (round-robin); with MEM_ARB_FIXED_PRIO_EN -> c0,c0,c0.
REQ-035 Base 0xFFFF_FFF8 read -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-036 rst=0 during beat 2 of a read -> next cycle all outputs 0, no done; after release a pending c1 req granted first.
